// File: rtl/afe_serial_pkg.sv
// afe_serial_pkg: shared types and widths for the AFE serial link.
// Command width matches the controller's command field.
package afe_serial_pkg;

    localparam int AFE_CMD_WIDTH = 20;
    localparam int AFE_RD_WIDTH  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } afe_state_e;

endpackage

// File: rtl/afe_sclk_gen.sv
// afe_sclk_gen: half-period counter producing SCLK and its edge strobes.
// Strobes mark the clk edge on which SCLK is about to toggle.
module afe_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic afe_sclk,
    output logic rise,
    output logic fall,
    output logic bit_done
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] half_cnt;
    logic          phase_end;

    assign phase_end = en && (half_cnt == HC_LAST);
    assign rise      = phase_end && !afe_sclk;
    assign fall      = phase_end && afe_sclk;
    assign bit_done  = fall;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            half_cnt <= '0;
            afe_sclk <= 1'b0;
        end else if (phase_end) begin
            half_cnt <= '0;
            afe_sclk <= ~afe_sclk;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/afe_serial_writer.sv
// afe_serial_writer: shifts one AFE command out MSB first per start pulse
// and returns the trailing read bits captured from afe_sdout.
module afe_serial_writer
    import afe_serial_pkg::*;
#(
    parameter int CMD_WIDTH = AFE_CMD_WIDTH,
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_IDLE   = 2,
    parameter int RD_WIDTH  = AFE_RD_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_transaction,
    input  logic [CMD_WIDTH-1:0] afe_command,
    output logic                 serial_ready,
    output logic                 afe_sclk,
    output logic                 afe_sdata,
    output logic                 afe_sen_n,
    input  logic                 afe_sdout,
    output logic [RD_WIDTH-1:0]  read_data,
    output logic                 read_valid
);

    localparam int BW    = $clog2(CMD_WIDTH + 1);
    localparam int T_A   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int T_MAX = (T_A > CS_IDLE) ? T_A : CS_IDLE;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(CS_IDLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(CMD_WIDTH - 1);

    afe_state_e            state, state_d;
    logic [TW-1:0]         tcnt, tcnt_d;
    logic [BW-1:0]         bit_cnt, bit_cnt_d;
    logic [CMD_WIDTH-1:0]  shreg, shreg_d;
    logic [RD_WIDTH-1:0]   cap, cap_d, read_data_d;
    logic                  ready_d, sen_n_d, sdata_d, valid_d;
    logic                  sclk_en, sclk_rise, sclk_fall, bit_done;

    assign sclk_en = (state == S_SHIFT);

    afe_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (sclk_en),
        .afe_sclk (afe_sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state;
        tcnt_d      = tcnt;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        cap_d       = cap;
        read_data_d = read_data;
        ready_d     = 1'b0;
        sen_n_d     = 1'b0;
        sdata_d     = afe_sdata;
        valid_d     = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready_d = 1'b1;
                sen_n_d = 1'b1;
                sdata_d = 1'b0;
                if (start_transaction && serial_ready) begin
                    state_d   = S_SETUP;
                    shreg_d   = afe_command;
                    sdata_d   = afe_command[CMD_WIDTH-1];
                    cap_d     = '0;
                    tcnt_d    = '0;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    sen_n_d   = 1'b0;
                end
            end
            S_SETUP: begin
                if (tcnt == SETUP_LAST) begin
                    state_d = S_SHIFT;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (sclk_rise)
                    cap_d = {cap[RD_WIDTH-2:0], afe_sdout};
                if (bit_done) begin
                    if (bit_cnt == BIT_LAST)
                        state_d = S_HOLD;
                    else
                        bit_cnt_d = bit_cnt + 1'b1;
                end
                // The last bit stays on the wire through HOLD.
                if (sclk_fall && bit_cnt != BIT_LAST) begin
                    shreg_d = shreg << 1;
                    sdata_d = shreg[CMD_WIDTH-2];
                end
            end
            S_HOLD: begin
                if (tcnt == HOLD_LAST) begin
                    state_d     = S_GAP;
                    tcnt_d      = '0;
                    sen_n_d     = 1'b1;
                    sdata_d     = 1'b0;
                    read_data_d = cap;
                    valid_d     = 1'b1;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            S_GAP: begin
                sen_n_d = 1'b1;
                sdata_d = 1'b0;
                if (tcnt == IDLE_LAST) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    tcnt_d = tcnt + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                sen_n_d = 1'b1;
                sdata_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tcnt         <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            cap          <= '0;
            serial_ready <= 1'b0;
            afe_sen_n    <= 1'b1;
            afe_sdata    <= 1'b0;
            read_data    <= '0;
            read_valid   <= 1'b0;
        end else begin
            state        <= state_d;
            tcnt         <= tcnt_d;
            bit_cnt      <= bit_cnt_d;
            shreg        <= shreg_d;
            cap          <= cap_d;
            serial_ready <= ready_d;
            afe_sen_n    <= sen_n_d;
            afe_sdata    <= sdata_d;
            read_data    <= read_data_d;
            read_valid   <= valid_d;
        end
    end

endmodule

// File: tb/tb_afe_serial_writer.sv
// tb_afe_serial_writer: directed checks of framing, timing and read capture
// for afe_serial_writer with default parameters.
module tb_afe_serial_writer;

    localparam int CW = 20;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_transaction = 1'b0;
    logic [CW-1:0] afe_command = '0;
    logic          afe_sdout = 1'b0;
    logic          serial_ready;
    logic          afe_sclk;
    logic          afe_sdata;
    logic          afe_sen_n;
    logic [RW-1:0] read_data;
    logic          read_valid;

    afe_serial_writer dut (
        .clk               (clk),
        .reset             (reset),
        .start_transaction (start_transaction),
        .afe_command       (afe_command),
        .serial_ready      (serial_ready),
        .afe_sclk          (afe_sclk),
        .afe_sdata         (afe_sdata),
        .afe_sen_n         (afe_sen_n),
        .afe_sdout         (afe_sdout),
        .read_data         (read_data),
        .read_valid        (read_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int s0       = 0;
    int clr_gen  = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // AFE response model: 20-bit word, read data in the last 16 slots
    logic [CW-1:0] resp = 20'h5BEEF;

    int            seen_gen = 0;
    int            rel;
    int            first_low, last_low, low_cnt;
    int            rises, txn_rises, first_rise, last_fall;
    int            rv_cnt, rv_cycle, rdy_cycle, hi_run, last_gap;
    logic          rdy_at1, prev_sclk, saw_low;
    logic [CW-1:0] sd_word;
    logic [RW-1:0] rv_data;

    always @(negedge clk) begin
        if (clr_gen != seen_gen) begin
            seen_gen   = clr_gen;
            first_low  = -1;
            last_low   = -1;
            low_cnt    = 0;
            rises      = 0;
            first_rise = -1;
            last_fall  = -1;
            rv_cnt     = 0;
            rv_cycle   = -1;
            rdy_cycle  = -1;
            hi_run     = 0;
            last_gap   = -1;
            rdy_at1    = 1'bx;
            saw_low    = 1'b0;
            sd_word    = '0;
            rv_data    = '0;
        end
        rel = ncyc - s0;
        if (rel == 1)
            rdy_at1 = serial_ready;
        if (afe_sen_n == 1'b0) begin
            if (first_low < 0)
                first_low = rel;
            last_low = rel;
            low_cnt++;
            if (saw_low && hi_run > 0)
                last_gap = hi_run;
            hi_run  = 0;
            saw_low = 1'b1;
        end else begin
            hi_run++;
            txn_rises = 0;
        end
        if (afe_sclk && !prev_sclk) begin
            rises++;
            txn_rises++;
            if (first_rise < 0)
                first_rise = rel;
            sd_word = {sd_word[CW-2:0], afe_sdata};
        end
        if (!afe_sclk && prev_sclk)
            last_fall = rel;
        prev_sclk = afe_sclk;
        if (read_valid) begin
            rv_cnt++;
            rv_cycle = rel;
            rv_data  = read_data;
        end
        if (serial_ready && rel >= 2 && rdy_cycle < 0 && first_low > 0)
            rdy_cycle = rel;
        if (afe_sen_n == 1'b0 && txn_rises < CW)
            afe_sdout = resp[CW-1-txn_rises];
        else
            afe_sdout = 1'b0;
    end

    initial begin
        prev_sclk = 1'b0;
        txn_rises = 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [CW-1:0] cmd, input bit clear);
        afe_command       = cmd;
        start_transaction = 1'b1;
        if (clear) begin
            clr_gen++;
            s0 = ncyc;
        end
        tick(1);
        start_transaction = 1'b0;
    endtask

    task automatic wait_ready;
        int n;
        n = 0;
        while (serial_ready !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("ready_wait", 32'(serial_ready), 32'd1);
    endtask

    task automatic check_txn(input string p);
        check({p, "_ready_c1"},   32'(rdy_at1),    32'd0);
        check({p, "_first_low"},  32'(first_low),  32'd1);
        check({p, "_last_low"},   32'(last_low),   32'd164);
        check({p, "_low_cnt"},    32'(low_cnt),    32'd164);
        check({p, "_rises"},      32'(rises),      32'd20);
        check({p, "_sdata"},      32'(sd_word),    32'hA5C3F);
        check({p, "_first_rise"}, 32'(first_rise), 32'd7);
        check({p, "_last_fall"},  32'(last_fall),  32'd163);
        check({p, "_rv_cnt"},     32'(rv_cnt),     32'd1);
        check({p, "_rv_cycle"},   32'(rv_cycle),   32'd165);
        check({p, "_rv_data"},    32'(rv_data),    32'hBEEF);
        check({p, "_read_data"},  32'(read_data),  32'hBEEF);
        check({p, "_ready_ret"},  32'(rdy_cycle),  32'd167);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_ready", 32'(serial_ready), 32'd0);
        check("rst_sen_n", 32'(afe_sen_n),    32'd1);
        check("rst_sclk",  32'(afe_sclk),     32'd0);
        check("rst_sdata", 32'(afe_sdata),    32'd0);
        check("rst_rdata", 32'(read_data),    32'd0);
        check("rst_valid", 32'(read_valid),   32'd0);
        reset = 1'b0;
        check("rel_ready_pre", 32'(serial_ready), 32'd0);
        tick(1);
        check("rel_ready_1", 32'(serial_ready), 32'd1);
        tick(5);
        check("idle_sen_n", 32'(afe_sen_n), 32'd1);
        check("idle_sclk",  32'(afe_sclk),  32'd0);

        wait_ready();
        issue(20'hA5C3F, 1'b1);
        tick(199);
        check_txn("single");

        wait_ready();
        issue(20'hA5C3F, 1'b1);
        tick(48);
        issue(20'h12345, 1'b0);
        tick(150);
        check_txn("dbl");

        wait_ready();
        issue(20'hA5C3F, 1'b1);
        tick(79);
        check("pre_rst_sclk", 32'(afe_sclk), 32'd1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sen_n", 32'(afe_sen_n),    32'd1);
        check("mid_rst_sclk",  32'(afe_sclk),     32'd0);
        check("mid_rst_ready", 32'(serial_ready), 32'd0);
        check("mid_rst_valid", 32'(read_valid),   32'd0);
        reset = 1'b0;
        tick(120);
        check("mid_rst_no_rv", 32'(rv_cnt),    32'd0);
        check("mid_rst_rdata", 32'(read_data), 32'd0);
        wait_ready();
        issue(20'hA5C3F, 1'b1);
        tick(199);
        check_txn("post_rst");

        wait_ready();
        issue(20'h0F0F0, 1'b1);
        wait_ready();
        issue(20'hA5C3F, 1'b0);
        tick(200);
        check("b2b_rv_cnt",  32'(rv_cnt),   32'd2);
        check("b2b_gap",     32'(last_gap), 32'd3);
        check("b2b_rises",   32'(rises),    32'd40);
        check("b2b_sdata",   32'(sd_word),  32'hA5C3F);
        check("b2b_rv_data", 32'(rv_data),  32'hBEEF);
        check("b2b_ready",   32'(serial_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
